// File: rtl/tt_response_checker.sv
// ----------------------------------------------------------------------------
// tt_response_checker
// Exhaustively drives a 4-input combinational DUT through vectors 0..15.
// Each vector is held for SETTLE cycles and then sampled for one cycle.
// Each response is compared against a latched 16-bit golden truth table.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         run request, honoured only while idle
//   expected      golden truth table, bit i = expected f for vector i
//   vec_a..vec_d  stimulus to the DUT, {vec_a,vec_b,vec_c,vec_d} = vector index
//   f_in          DUT response under test
//   busy          high from the first cycle after an accepted start through DONE
//   done          one-cycle completion pulse
//   pass          last completed run had zero mismatches
//   mismatch_map  bit i set when vector i mismatched
//   err_count     number of mismatching vectors in the last run (0..16)
// ----------------------------------------------------------------------------
module tt_response_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        vec_a,
    output logic        vec_b,
    output logic        vec_c,
    output logic        vec_d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_map,
    output logic [4:0]  err_count
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned TT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TT_W-1:0]    exp_q;
    logic [TT_W-1:0]    map_q;
    logic [ERR_W-1:0]   err_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    // Compare the current response against the latched golden bit
    logic               miss_c;
    logic [ERR_W-1:0]   err_inc_c;

    always_comb begin
        miss_c    = f_in ^ exp_q[idx_q];
        err_inc_c = err_q + ERR_W'(miss_c);
    end

    // Sequencer: state, vector index, settle counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            map_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        map_q   <= '0;
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Hold the vector for exactly SETTLE cycles
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (miss_c) begin
                        map_q[idx_q] <= 1'b1;
                        err_q        <= err_inc_c;
                    end
                    if (idx_q != IDX_W'(15)) begin
                        idx_q   <= idx_q + IDX_W'(1);
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end else begin
                        // Verdict includes the final sample so it is valid alongside done
                        done_q  <= 1'b1;
                        pass_q  <= (err_inc_c == '0);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign {vec_a, vec_b, vec_c, vec_d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_map = map_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// ----------------------------------------------------------------------------
// Bench for tt_response_checker: a behavioural DUT model answers the stimulus.
// Expected results come from the truth-table rules over all 16 vectors.
// ----------------------------------------------------------------------------
module tb_tt_response_checker;

    localparam int unsigned S       = 2;
    localparam int          RUN_LEN = 1 + 16 * (S + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic        vec_a, vec_b, vec_c, vec_d;
    logic        busy, done, pass;
    logic [15:0] mismatch_map;
    logic [4:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Response model: 0 golden, 1 tied low, 2 tied high, 3 golden with flipped vectors
    int          mode = 1;
    logic [15:0] exp_lat = '0;
    logic [15:0] flip = '0;
    logic [3:0]  abcd;

    tt_response_checker #(.SETTLE(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .expected     (expected),
        .f_in         (f_in),
        .vec_a        (vec_a),
        .vec_b        (vec_b),
        .vec_c        (vec_c),
        .vec_d        (vec_d),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_map (mismatch_map),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic model_f(input int m, input logic [15:0] e,
                                     input logic [15:0] fl, input int v);
        logic [15:0] ev;
        logic [15:0] fv;
        ev = e;
        fv = fl;
        case (m)
            0:       return ev[v];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ev[v] ^ fv[v];
        endcase
    endfunction

    assign abcd = {vec_a, vec_b, vec_c, vec_d};

    always_comb f_in = model_f(mode, exp_lat, flip, int'(abcd));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: start accepted in the cycle before t=1; t counts cycles after acceptance.
    task automatic run(input int m, input logic [15:0] e, input logic [15:0] fl,
                       input int inject_at, input int rst_at);
        logic [15:0] emap;
        int          ecnt;
        int          ev;
        mode     = m;
        flip     = fl;
        expected = e;
        exp_lat  = e;
        emap     = '0;
        ecnt     = 0;
        for (int v = 0; v < 16; v++) begin
            if (model_f(m, e, fl, v) != e[v]) begin
                emap[v] = 1'b1;
                ecnt++;
            end
        end
        start = 1'b1;
        for (int t = 1; t <= RUN_LEN + 1; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) start = 1'b0;
            if (rst_at != 0 && t == rst_at + 1) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_vec", 32'(abcd), 32'd0);
                chk("rst_err", 32'(err_count), 32'd0);
                chk("rst_map", 32'(mismatch_map), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk);
                    #1;
                    chk("rst_no_done", 32'(done), 32'd0);
                end
                return;
            end
            if (t < RUN_LEN) begin
                ev = (t - 1) / int'(S + 1);
                chk("vec_seq", 32'(abcd), 32'(ev));
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
            end else if (t == RUN_LEN) begin
                chk("done_cycle", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd1);
                chk("pass", 32'(pass), 32'(ecnt == 0));
                chk("map", 32'(mismatch_map), 32'(emap));
                chk("err_count", 32'(err_count), 32'(ecnt));
            end else begin
                chk("done_pulse", 32'(done), 32'd0);
                chk("busy_after", 32'(busy), 32'd0);
                chk("idx_hold", 32'(abcd), 32'd15);
                chk("pass_hold", 32'(pass), 32'(ecnt == 0));
                chk("map_hold", 32'(mismatch_map), 32'(emap));
                chk("err_hold", 32'(err_count), 32'(ecnt));
            end
            if (inject_at != 0 && t == inject_at) start = 1'b1;
            if (inject_at != 0 && t == inject_at + 1) start = 1'b0;
            if (inject_at != 0 && t == inject_at + 2) expected = ~e;
            if (rst_at != 0 && t == rst_at) rst = 1'b1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        expected = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_map", 32'(mismatch_map), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        chk("reset_vec", 32'(abcd), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        run(0, 16'hA5C3, 16'h0000, 0, 0);
        run(1, 16'h0001, 16'h0000, 0, 0);
        run(2, 16'h0000, 16'h0000, 0, 0);
        run(3, 16'h5A5A, 16'hFFFF, 0, 0);
        for (int r = 0; r < 4; r++) begin
            run(3, 16'($urandom), 16'($urandom), 0, 0);
        end
        run(3, 16'h3C69, 16'h0421, 10, 0);
        run(3, 16'($urandom), 16'hFFFF, 0, 20);
        run(3, 16'($urandom), 16'($urandom), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
